// File: rtl/red_pitaya_daisy_pkg.sv
// Shared encodings for the daisy-chain PRBS generator/checker: pattern modes,
// checker FSM states and the LFSR order/tap table.
package red_pitaya_daisy_pkg;

  typedef enum logic [1:0] {
    MODE_PRBS7  = 2'd0,
    MODE_PRBS15 = 2'd1,
    MODE_PRBS31 = 2'd2,
    MODE_CNT    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } chk_state_e;

  localparam int LFSR_W = 32;

  // Polynomial x^order + x^tap + 1; the counter pattern needs a one-word history.
  function automatic int lfsr_order(mode_e m);
    case (m)
      MODE_PRBS7:  return 7;
      MODE_PRBS15: return 15;
      MODE_PRBS31: return 31;
      default:     return 1;
    endcase
  endfunction

  function automatic int lfsr_tap(mode_e m);
    case (m)
      MODE_PRBS7:  return 6;
      MODE_PRBS15: return 14;
      MODE_PRBS31: return 28;
      default:     return 1;
    endcase
  endfunction

endpackage

// File: rtl/red_pitaya_daisy_prbs_lane.sv
// One daisy lane: pattern generator plus a self-synchronising checker with
// lock tracking and saturating error/word counters.
module red_pitaya_daisy_prbs_lane
  import red_pitaya_daisy_pkg::*;
#(
  parameter int LANE       = 0,
  parameter int DW         = 16,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W      = 32
) (
  input  logic             par_clk_i,
  input  logic             par_rstn_i,
  input  logic             cfg_en_i,
  input  mode_e            cfg_mode_i,
  input  logic             mode_chg_i,
  input  logic             cfg_clr_i,
  input  logic             tx_rdy_i,
  output logic             tx_dv_o,
  output logic [DW-1:0]    tx_dat_o,
  input  logic             rx_dv_i,
  input  logic [DW-1:0]    rx_dat_i,
  output logic             stat_lock_o,
  output logic [CNT_W-1:0] stat_err_o,
  output logic [CNT_W-1:0] stat_dat_o
);

  localparam logic [LFSR_W-1:0] LFSR_SEED = {LFSR_W{1'b1}} ^ LFSR_W'(LANE);

  // Produces the next DW pattern bits (MSB first) and the advanced state.
  function automatic logic [LFSR_W+DW-1:0] next_word(input logic [LFSR_W-1:0] s, input mode_e m);
    logic [LFSR_W-1:0] st;
    logic [DW-1:0]     w;
    logic [4:0]        ord_i;
    logic [4:0]        tap_i;
    logic              nb;
    st    = s;
    w     = '0;
    ord_i = 5'(lfsr_order(m) - 1);
    tap_i = 5'(lfsr_tap(m) - 1);
    if (m == MODE_CNT) begin
      w  = s[DW-1:0] + DW'(1);
      st = LFSR_W'(w);
    end else begin
      for (int i = DW - 1; i >= 0; i--) begin
        nb   = st[ord_i] ^ st[tap_i];
        st   = {st[LFSR_W-2:0], nb};
        w[i] = nb;
      end
    end
    return {st, w};
  endfunction

  chk_state_e        state;
  logic [LFSR_W-1:0] gen_s, gen_nxt, pred, pred_nxt, hist, hist_nxt;
  logic [DW-1:0]     gen_word, pred_word;
  logic [2:0]        seed_cnt, seed_words;
  logic [15:0]       good_cnt, bad_cnt;
  logic              match, chk_act, err_inc;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    {gen_nxt, gen_word}   = next_word(gen_s, cfg_mode_i);
    {pred_nxt, pred_word} = next_word(pred, cfg_mode_i);
    hist_nxt   = LFSR_W'({hist, rx_dat_i});
    seed_words = 3'((lfsr_order(cfg_mode_i) + DW - 1) / DW);
    match      = (rx_dat_i == pred_word);
    chk_act    = cfg_en_i & ~mode_chg_i & rx_dv_i &
                 ((state == ST_VERIFY) | (state == ST_LOCKED));
    err_inc    = chk_act & (state == ST_LOCKED) & ~match;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge par_clk_i) begin
    if (!par_rstn_i) begin
      gen_s       <= (cfg_mode_i == MODE_CNT) ? '0 : LFSR_SEED;
      tx_dv_o     <= 1'b0;
      tx_dat_o    <= '0;
      state       <= ST_IDLE;
      pred        <= '0;
      hist        <= '0;
      seed_cnt    <= '0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      stat_lock_o <= 1'b0;
      stat_err_o  <= '0;
      stat_dat_o  <= '0;
    end else begin
      if (mode_chg_i) begin
        gen_s   <= (cfg_mode_i == MODE_CNT) ? '0 : LFSR_SEED;
        tx_dv_o <= 1'b0;
      end else if (cfg_en_i && tx_rdy_i) begin
        gen_s    <= gen_nxt;
        tx_dat_o <= gen_word;
        tx_dv_o  <= 1'b1;
      end else begin
        tx_dv_o <= 1'b0;
      end

      if (!cfg_en_i) begin
        state       <= ST_IDLE;
        stat_lock_o <= 1'b0;
      end else if (mode_chg_i) begin
        state       <= ST_SEED;
        seed_cnt    <= '0;
        stat_lock_o <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_SEED;
            seed_cnt <= '0;
          end
          ST_SEED: if (rx_dv_i) begin
            hist <= hist_nxt;
            if (seed_cnt == seed_words - 3'd1) begin
              pred     <= hist_nxt;
              good_cnt <= '0;
              state    <= ST_VERIFY;
            end else begin
              seed_cnt <= seed_cnt + 3'd1;
            end
          end
          ST_VERIFY: if (rx_dv_i) begin
            pred <= pred_nxt;
            if (!match) begin
              state    <= ST_SEED;
              seed_cnt <= '0;
            end else if (good_cnt == 16'(LOCK_CNT - 1)) begin
              state       <= ST_LOCKED;
              stat_lock_o <= 1'b1;
              bad_cnt     <= '0;
            end else begin
              good_cnt <= good_cnt + 16'd1;
            end
          end
          ST_LOCKED: if (rx_dv_i) begin
            pred <= pred_nxt;
            if (match) begin
              bad_cnt <= '0;
            end else if (bad_cnt == 16'(UNLOCK_ERR - 1)) begin
              state       <= ST_SEED;
              seed_cnt    <= '0;
              stat_lock_o <= 1'b0;
            end else begin
              bad_cnt <= bad_cnt + 16'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // Clear wins over a same-cycle increment; counters stick at all-ones.
      if (cfg_clr_i) begin
        stat_err_o <= '0;
        stat_dat_o <= '0;
      end else begin
        if (chk_act && stat_dat_o != '1) stat_dat_o <= stat_dat_o + CNT_W'(1);
        if (err_inc && stat_err_o != '1) stat_err_o <= stat_err_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/red_pitaya_daisy_prbs.sv
// Multi-lane daisy-chain PRBS generator/checker; detects pattern changes and
// fans the reseed request out to every lane.
module red_pitaya_daisy_prbs
  import red_pitaya_daisy_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DW         = 16,
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4,
  parameter int CNT_W      = 32
) (
  input  logic                   par_clk_i,
  input  logic                   par_rstn_i,
  input  logic                   cfg_en_i,
  input  logic [1:0]             cfg_mode_i,
  input  logic                   cfg_clr_i,
  input  logic [LANES-1:0]       tx_rdy_i,
  output logic [LANES-1:0]       tx_dv_o,
  output logic [LANES*DW-1:0]    tx_dat_o,
  input  logic [LANES-1:0]       rx_dv_i,
  input  logic [LANES*DW-1:0]    rx_dat_i,
  output logic [LANES-1:0]       stat_lock_o,
  output logic [LANES*CNT_W-1:0] stat_err_o,
  output logic [LANES*CNT_W-1:0] stat_dat_o
);

  mode_e mode, mode_q;
  logic  en_q, mode_chg;

  assign mode = mode_e'(cfg_mode_i);
  // Only a change seen across two enabled cycles counts, so enabling never reseeds.
  assign mode_chg = cfg_en_i & en_q & (mode != mode_q);

  always_ff @(posedge par_clk_i) begin
    if (!par_rstn_i) begin
      en_q   <= 1'b0;
      mode_q <= MODE_PRBS7;
    end else begin
      en_q   <= cfg_en_i;
      mode_q <= mode;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    red_pitaya_daisy_prbs_lane #(
      .LANE(l), .DW(DW), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(CNT_W)
    ) u_lane (
      .par_clk_i   (par_clk_i),
      .par_rstn_i  (par_rstn_i),
      .cfg_en_i    (cfg_en_i),
      .cfg_mode_i  (mode),
      .mode_chg_i  (mode_chg),
      .cfg_clr_i   (cfg_clr_i),
      .tx_rdy_i    (tx_rdy_i[l]),
      .tx_dv_o     (tx_dv_o[l]),
      .tx_dat_o    (tx_dat_o[l*DW +: DW]),
      .rx_dv_i     (rx_dv_i[l]),
      .rx_dat_i    (rx_dat_i[l*DW +: DW]),
      .stat_lock_o (stat_lock_o[l]),
      .stat_err_o  (stat_err_o[l*CNT_W +: CNT_W]),
      .stat_dat_o  (stat_dat_o[l*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_red_pitaya_daisy_prbs.sv
// Bench for red_pitaya_daisy_prbs: a 32-bit-counter and a 4-bit-counter instance
// share stimulus and are compared every cycle against a bit-stream reference model.
module tb_red_pitaya_daisy_prbs;

  localparam int LANES = 2, DW = 16, LOCK_CNT = 8, UNLOCK_ERR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rstn, en, clr, loop;
  logic [1:0]          mode;
  logic [LANES-1:0]    rdy, drv_dv;
  logic [LANES*DW-1:0] drv_dat, flip;

  logic [LANES-1:0]    tx_dv, tx_dv4, lock, lock4, rx_dv;
  logic [LANES*DW-1:0] tx_dat, tx_dat4, rx_dat;
  logic [LANES*32-1:0] err, dat;
  logic [LANES*4-1:0]  err4, dat4;

  assign rx_dv  = loop ? tx_dv : drv_dv;
  assign rx_dat = loop ? (tx_dat ^ flip) : drv_dat;

  red_pitaya_daisy_prbs #(.LANES(LANES), .DW(DW), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(32)) dut (
    .par_clk_i(clk), .par_rstn_i(rstn), .cfg_en_i(en), .cfg_mode_i(mode), .cfg_clr_i(clr),
    .tx_rdy_i(rdy), .tx_dv_o(tx_dv), .tx_dat_o(tx_dat), .rx_dv_i(rx_dv), .rx_dat_i(rx_dat),
    .stat_lock_o(lock), .stat_err_o(err), .stat_dat_o(dat));

  red_pitaya_daisy_prbs #(.LANES(LANES), .DW(DW), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .CNT_W(4)) dut4 (
    .par_clk_i(clk), .par_rstn_i(rstn), .cfg_en_i(en), .cfg_mode_i(mode), .cfg_clr_i(clr),
    .tx_rdy_i(rdy), .tx_dv_o(tx_dv4), .tx_dat_o(tx_dat4), .rx_dv_i(rx_dv), .rx_dat_i(rx_dat),
    .stat_lock_o(lock4), .stat_err_o(err4), .stat_dat_o(dat4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int l, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lane %0d observed %0h expected %0h", tag, l, obs, exp);
    end
  endtask

  // Reference model: index l = generator of lane l, LANES+l = checker predictor of lane l.
  bit                q[2*LANES][$];
  logic [DW-1:0]     m_cnt[2*LANES];
  bit                m_tdv[LANES];
  logic [DW-1:0]     m_tdat[LANES];
  int                m_phase[LANES];   // 0 idle, 1 seeding, 2 verifying, 3 locked
  int                m_seen[LANES], m_good[LANES], m_bad[LANES];
  longint unsigned   m_err[LANES], m_dat[LANES];
  bit                m_en_q;
  logic [1:0]        m_mode_q;

  function automatic int order_of(input logic [1:0] md);
    return (md == 2'd0) ? 7 : (md == 2'd1) ? 15 : (md == 2'd2) ? 31 : 1;
  endfunction

  function automatic int tap_of(input logic [1:0] md);
    return (md == 2'd0) ? 6 : (md == 2'd1) ? 14 : 28;
  endfunction

  function automatic longint unsigned sat4(input longint unsigned v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic reseed(input int l);
    logic [31:0] s;
    s = 32'hFFFF_FFFF ^ 32'(l);
    q[l].delete();
    for (int i = 30; i >= 0; i--) q[l].push_back(s[i]);
    m_cnt[l] = '0;
  endtask

  task automatic next_word(input int idx, input logic [1:0] md, output logic [DW-1:0] w);
    int n, t;
    bit b;
    w = '0;
    if (md == 2'd3) begin
      m_cnt[idx] = m_cnt[idx] + 1'b1;
      w = m_cnt[idx];
    end else begin
      n = order_of(md);
      t = tap_of(md);
      for (int i = DW - 1; i >= 0; i--) begin
        b = q[idx][q[idx].size() - n] ^ q[idx][q[idx].size() - t];
        q[idx].push_back(b);
        w[i] = b;
      end
      while (q[idx].size() > 64) void'(q[idx].pop_front());
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) begin
      reseed(l);
      m_tdv[l] = 0; m_tdat[l] = '0; m_phase[l] = 0;
      m_err[l] = 0; m_dat[l] = 0;
    end
    m_en_q = 0;
    m_mode_q = 2'd0;
  endtask

  // Advances the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit            mchg, rdv, active, match;
    logic [DW-1:0] rdat, pw;
    if (!rstn) begin
      model_reset();
      return;
    end
    mchg = en && m_en_q && (mode != m_mode_q);
    for (int l = 0; l < LANES; l++) begin
      rdv   = loop ? m_tdv[l] : drv_dv[l];
      rdat  = loop ? (m_tdat[l] ^ flip[l*DW +: DW]) : drv_dat[l*DW +: DW];
      active = en && !mchg && rdv && (m_phase[l] >= 2);
      match = 0;
      if (active) begin
        next_word(LANES + l, mode, pw);
        match = (pw == rdat);
      end
      if (clr) begin
        m_err[l] = 0; m_dat[l] = 0;
      end else if (active) begin
        m_dat[l]++;
        if (m_phase[l] == 3 && !match) m_err[l]++;
      end
      if (!en) m_phase[l] = 0;
      else if (mchg) begin m_phase[l] = 1; m_seen[l] = 0; end
      else if (m_phase[l] == 0) begin m_phase[l] = 1; m_seen[l] = 0; end
      else if (m_phase[l] == 1 && rdv) begin
        for (int i = DW - 1; i >= 0; i--) q[LANES + l].push_back(rdat[i]);
        m_cnt[LANES + l] = rdat;
        m_seen[l]++;
        if (m_seen[l] == (order_of(mode) + DW - 1) / DW) begin m_phase[l] = 2; m_good[l] = 0; end
      end else if (m_phase[l] == 2 && rdv) begin
        if (!match) begin m_phase[l] = 1; m_seen[l] = 0; end
        else if (++m_good[l] == LOCK_CNT) begin m_phase[l] = 3; m_bad[l] = 0; end
      end else if (m_phase[l] == 3 && rdv) begin
        if (match) m_bad[l] = 0;
        else if (++m_bad[l] == UNLOCK_ERR) begin m_phase[l] = 1; m_seen[l] = 0; end
      end
      if (mchg) begin
        reseed(l);
        m_tdv[l] = 0;
      end else if (en && rdy[l]) begin
        next_word(l, mode, m_tdat[l]);
        m_tdv[l] = 1;
      end else m_tdv[l] = 0;
    end
    m_en_q = en;
    m_mode_q = mode;
  endtask

  task automatic compare_all();
    for (int l = 0; l < LANES; l++) begin
      check("tx_dv", l, 64'(tx_dv[l]), 64'(m_tdv[l]));
      check("tx_dat", l, 64'(tx_dat[l*DW +: DW]), 64'(m_tdat[l]));
      check("lock", l, 64'(lock[l]), 64'(m_phase[l] == 3));
      check("err", l, 64'(err[l*32 +: 32]), m_err[l]);
      check("dat", l, 64'(dat[l*32 +: 32]), m_dat[l]);
      check("tx_dat4", l, 64'(tx_dat4[l*DW +: DW]), 64'(m_tdat[l]));
      check("lock4", l, 64'(lock4[l]), 64'(m_phase[l] == 3));
      check("err4", l, 64'(err4[l*4 +: 4]), sat4(m_err[l]));
      check("dat4", l, 64'(dat4[l*4 +: 4]), sat4(m_dat[l]));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive_word(input logic [DW-1:0] w, input bit v);
    drv_dv  = v ? '1 : '0;
    drv_dat = {w, w};
    step();
  endtask

  logic [DW-1:0] seq_a[12] = '{16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009, 16'h000A,
                               16'h000B, 16'h000C, 16'h000D, 16'h000E, 16'h0010, 16'h0011};
  logic [DW-1:0] seq_b[10] = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000,
                               16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 0; en = 1; clr = 0; loop = 1; mode = 2'd1;
    rdy = '1; drv_dv = '0; drv_dat = '0; flip = '0;
    model_reset();
    repeat (2) step();
    rstn = 1;
    repeat (20) step();

    // Single-bit error on lane 0 while locked.
    flip = '0; flip[3] = 1'b1;
    step();
    flip = '0;
    repeat (5) step();

    // Four consecutive bad words on lane 1, then relock.
    repeat (4) begin
      flip = '0;
      flip[DW +: DW] = DW'($urandom_range(1, (1 << DW) - 1));
      step();
    end
    flip = '0;
    repeat (12) step();

    // Random readiness and sparse corruption in every pattern mode.
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      repeat (120) begin
        rdy  = LANES'($urandom);
        flip = ($urandom_range(0, 19) == 0) ? (LANES*DW)'($urandom) : '0;
        step();
      end
    end

    // Error counter saturation and clear on an error cycle.
    mode = 2'd1; rdy = '1; flip = '0;
    repeat (12) step();
    repeat (6) begin
      repeat (3) begin flip = (LANES*DW)'($urandom) | 32'h0001_0001; step(); end
      flip = '0;
      step();
    end
    flip = 32'h0001_0001; clr = 1;
    step();
    clr = 0; flip = '0;
    repeat (3) step();

    // Disable/enable and a one-cycle reset while locked.
    en = 0;
    repeat (3) step();
    en = 1;
    repeat (12) step();
    rstn = 0;
    step();
    rstn = 1;
    repeat (12) step();

    // Directed counter-mode words, including a gap and the 0xFFFF -> 0x0000 wrap.
    loop = 0; mode = 2'd3;
    drive_word('0, 0);
    foreach (seq_a[i]) drive_word(seq_a[i], 1);
    en = 0;
    drive_word('0, 0);
    en = 1;
    drive_word('0, 0);
    foreach (seq_b[i]) begin
      drive_word(seq_b[i], 1);
      if (i == 4) drive_word(16'h1234, 0);
    end
    repeat (2) drive_word('0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/red_pitaya_daisy_prbs.md
RED_PITAYA_DAISY_PRBS -- requirements
Module: red_pitaya_daisy_prbs

Interface
REQ-001 SHALL have parameter LANES, default 2, number of independent daisy lanes (1..8).
REQ-002 SHALL have parameter DW, default 16, parallel word width per lane (8..32).
REQ-003 SHALL have parameter LOCK_CNT, default 8, consecutive good words needed to declare lock.
REQ-004 SHALL have parameter UNLOCK_ERR, default 4, consecutive bad words that drop lock.
REQ-005 SHALL have parameter CNT_W, default 32, width of the statistics counters.
REQ-006 SHALL have port par_clk_i, input, 1, the single clock for all logic.
REQ-007 SHALL have port par_rstn_i, input, 1, reset: synchronous, active-low.
REQ-008 SHALL have port cfg_en_i, input, 1, enables generators and checkers.
REQ-009 SHALL have port cfg_mode_i, input, 2, pattern select: 0 PRBS7 (x^7+x^6+1), 1 PRBS15 (x^15+x^14+1), 2 PRBS31 (x^31+x^28+1), 3 incrementing counter.
REQ-010 SHALL have port cfg_clr_i, input, 1, level clear of all statistics counters.
REQ-011 SHALL have port tx_rdy_i, input, LANES, per-lane transmitter ready.
REQ-012 SHALL have port tx_dv_o, output, LANES, per-lane generated word valid.
REQ-013 SHALL have port tx_dat_o, output, LANES*DW, generated words, lane l at bits [l*DW +: DW].
REQ-014 SHALL have port rx_dv_i, input, LANES, per-lane received word valid.
REQ-015 SHALL have port rx_dat_i, input, LANES*DW, received words, same packing as tx_dat_o.
REQ-016 SHALL have port stat_lock_o, output, LANES, per-lane checker locked.
REQ-017 SHALL have port stat_err_o, output, LANES*CNT_W, per-lane error word counters.
REQ-018 SHALL have port stat_dat_o, output, LANES*CNT_W, per-lane checked word counters.

Function
REQ-019 Generator: when cfg_en_i and tx_rdy_i[l] are high, tx_dat_o[l] SHALL load the next DW pattern bits (MSB = earliest bit) and tx_dv_o[l] SHALL be 1 the next cycle; otherwise tx_dv_o[l] = 0 and tx_dat_o[l] holds.
REQ-020 Generator LFSR seed SHALL be all-ones XOR l; counter mode seed SHALL be 0, so the first emitted counter word is 1; the counter wraps 2^DW-1 -> 0.
REQ-021 Each lane checker SHALL be an FSM with states IDLE, SEED, VERIFY, LOCKED; cfg_en_i low forces IDLE from any state.
REQ-022 IDLE -> SEED when cfg_en_i is high.
REQ-023 SEED SHALL shift rx_dv_i-qualified words into a bit history; after ceil(order/DW) words (order 7/15/31; 1 for counter) it SHALL load the checker predictor and go to VERIFY.
REQ-024 VERIFY: each valid word SHALL be compared with the predicted word; LOCK_CNT consecutive matches -> LOCKED; any mismatch -> SEED.
REQ-025 LOCKED: a mismatch SHALL increment stat_err_o[l]; UNLOCK_ERR consecutive mismatches -> SEED; any match resets the consecutive-mismatch count.
REQ-026 The predictor SHALL advance only on rx_dv_i[l], and SHALL free-run from its own state (it is not reseeded from data) in VERIFY and LOCKED.
REQ-027 stat_lock_o[l] SHALL be 1 exactly while the lane is in LOCKED, registered.
REQ-028 stat_dat_o[l] SHALL increment on every valid word received in VERIFY or LOCKED.
REQ-029 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-030 cfg_clr_i SHALL zero both counters of every lane and SHALL win over a same-cycle increment; FSM state is unaffected.
REQ-031 A change of cfg_mode_i while enabled SHALL reseed all generators and send all enabled checkers to SEED on the next cycle.

Reset
REQ-032 par_rstn_i low SHALL set tx_dv_o=0, tx_dat_o=0, stat_lock_o=0, stat_err_o=0, stat_dat_o=0, all FSMs to IDLE and generators to their seeds; reset mid-operation SHALL take effect on the next edge.

Structure
REQ-033 The mode encodings, the LFSR tap/order table and the FSM state encoding SHALL live in a shared package red_pitaya_daisy_pkg.
REQ-034 Per-lane generator and checker logic SHALL be one sub-module, red_pitaya_daisy_prbs_lane, instantiated LANES times by generate.

Verification
REQ-035 PRBS15, DW=16, tx looped to rx, tx_rdy_i all 1 -> lock after 1 seed + 8 words on both lanes, stat_err_o=0, stat_dat_o increases by 1 per cycle.
REQ-036 Locked lane 0, flip rx bit 3 of one word -> stat_err_o[0]=1, lock retained, lane 1 unaffected.
REQ-037 Corrupt 4 consecutive words on lane 1 -> lock drops after the 4th, then relocks after 1+8 clean words.
REQ-038 Counter mode, rx sequence 0x0005,0x0006..0x000E then 0x0010 -> lock, then err=1; 0xFFFF -> 0x0000 counts as a match.
REQ-039 CNT_W=4 with continuous errors -> stat_err_o saturates at 15; cfg_clr_i asserted on an error cycle -> 0.
REQ-040 par_rstn_i low for 1 cycle while locked -> all outputs 0 next cycle, relock follows REQ-035 timing.
